io_mem_burst_engine: RTL and testbench

//  Memory-side bridge for the conv2D accelerator. Accepts burst read/write requests
//  (addr + length) from the compute block and splits them into single-beat memory ops.

---
 rtl/io_mem_burst_if.sv | 64 ++++++
 rtl/io_mem_burst_engine.sv | 136 +++++++++++++
 tb/tb_io_mem_burst_engine.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_mem_burst_if.sv
// Burst request, read-data, write-status and single-beat memory port bundle for io_mem_burst_engine.
interface io_mem_burst_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    logic [AWIDTH-1:0] req_read_addr;
    logic              req_read_addr_valid;
    logic              req_read_addr_ready;
    logic [31:0]       req_read_len;
    logic [DWIDTH-1:0] rdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [AWIDTH-1:0] req_write_addr;
    logic              req_write_addr_valid;
    logic              req_write_addr_ready;
    logic [31:0]       req_write_len;
    logic [DWIDTH-1:0] req_write_data;
    logic              req_write_data_valid;
    logic              req_write_data_ready;
    logic              resp_write_status;
    logic              resp_write_status_valid;
    logic              resp_write_status_ready;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [AWIDTH-1:0] mem_req_addr;
    logic [DWIDTH-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DWIDTH-1:0] mem_resp_data;

    // Engine view
    modport slave (
        input  req_read_addr, req_read_addr_valid, req_read_len,
        output req_read_addr_ready,
        output rdata, rdata_valid,
        input  rdata_ready,
        input  req_write_addr, req_write_addr_valid, req_write_len,
        output req_write_addr_ready,
        input  req_write_data, req_write_data_valid,
        output req_write_data_ready,
        output resp_write_status, resp_write_status_valid,
        input  resp_write_status_ready,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_data
    );

    // Compute block + memory view
    modport master (
        output req_read_addr, req_read_addr_valid, req_read_len,
        input  req_read_addr_ready,
        input  rdata, rdata_valid,
        output rdata_ready,
        output req_write_addr, req_write_addr_valid, req_write_len,
        input  req_write_addr_ready,
        output req_write_data, req_write_data_valid,
        input  req_write_data_ready,
        input  resp_write_status, resp_write_status_valid,
        output resp_write_status_ready,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/io_mem_burst_engine.sv
// Splits burst read/write requests into single-beat memory ops, one burst at a time.
// Read data returns through a small in-order FIFO bounded by an outstanding-beat credit.
module io_mem_burst_engine #(
    parameter int unsigned AWIDTH          = 32,
    parameter int unsigned DWIDTH          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic          clk,
    input  logic          rst,
    io_mem_burst_if.slave bus
);
    localparam int unsigned STEP = DWIDTH / 8;
    localparam int unsigned IW   = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW   = IW + 1;

    typedef enum logic [1:0] {IDLE, RD, WR, WR_RESP} state_t;

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] base;
    logic [31:0]       len, issued, delivered;
    logic [CW-1:0]     credit;
    logic [CW-1:0]     wr_ptr, rd_ptr;
    logic [DWIDTH-1:0] fifo_mem [MAX_OUTSTANDING];

    logic              more_issue, fifo_empty, mem_fire, rd_fire, rd_issue_fire;
    logic              rd_acc, wr_acc, push;
    logic [AWIDTH-1:0] beat_addr;
    logic [DWIDTH-1:0] fifo_head;

    assign more_issue    = issued < len;
    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_head     = fifo_mem[wr_ptr[IW-1:0] == rd_ptr[IW-1:0] ? rd_ptr[IW-1:0] : rd_ptr[IW-1:0]];
    assign beat_addr     = base + AWIDTH'(issued * STEP);
    assign mem_fire      = bus.mem_req_valid & bus.mem_req_ready;
    assign rd_issue_fire = mem_fire & ~bus.mem_req_we;
    assign rd_fire       = bus.rdata_valid & bus.rdata_ready;
    assign rd_acc        = bus.req_read_addr_valid & bus.req_read_addr_ready;
    assign wr_acc        = bus.req_write_addr_valid & bus.req_write_addr_ready;
    assign push          = (state == RD) & bus.mem_resp_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (rd_acc)      state_nxt = (bus.req_read_len != 32'd0) ? RD : IDLE;
                else if (wr_acc) state_nxt = (bus.req_write_len != 32'd0) ? WR : WR_RESP;
            end
            RD:      if (rd_fire && (delivered == len - 32'd1)) state_nxt = IDLE;
            WR:      if (mem_fire && (issued == len - 32'd1))   state_nxt = WR_RESP;
            WR_RESP: if (bus.resp_write_status_ready)           state_nxt = IDLE;
        endcase
    end

    // Outputs; everything is held at zero while reset is asserted
    always_comb begin
        bus.req_read_addr_ready     = 1'b0;
        bus.req_write_addr_ready    = 1'b0;
        bus.req_write_data_ready    = 1'b0;
        bus.rdata                   = '0;
        bus.rdata_valid             = 1'b0;
        bus.resp_write_status       = 1'b0;
        bus.resp_write_status_valid = 1'b0;
        bus.mem_req_valid           = 1'b0;
        bus.mem_req_we              = 1'b0;
        bus.mem_req_addr            = '0;
        bus.mem_req_wdata           = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    bus.req_read_addr_ready  = 1'b1;
                    bus.req_write_addr_ready = ~bus.req_read_addr_valid;
                end
                RD: begin
                    bus.mem_req_valid = more_issue & (credit < CW'(MAX_OUTSTANDING));
                    bus.mem_req_addr  = beat_addr;
                    bus.rdata_valid   = ~fifo_empty;
                    bus.rdata         = fifo_empty ? '0 : fifo_head;
                end
                WR: begin
                    bus.mem_req_valid        = bus.req_write_data_valid & more_issue;
                    bus.mem_req_we           = 1'b1;
                    bus.mem_req_addr         = beat_addr;
                    bus.mem_req_wdata        = bus.req_write_data;
                    bus.req_write_data_ready = bus.mem_req_ready & more_issue;
                end
                WR_RESP: begin
                    bus.resp_write_status_valid = 1'b1;
                    bus.resp_write_status       = 1'b1;
                end
            endcase
        end
    end

    // Burst counters, credit and return-FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base      <= '0;
            len       <= '0;
            issued    <= '0;
            delivered <= '0;
            credit    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            if (rd_acc || wr_acc) begin
                base      <= rd_acc ? bus.req_read_addr : bus.req_write_addr;
                len       <= rd_acc ? bus.req_read_len : bus.req_write_len;
                issued    <= '0;
                delivered <= '0;
                credit    <= '0;
            end else begin
                if (mem_fire) issued    <= issued + 32'd1;
                if (rd_fire)  delivered <= delivered + 32'd1;
                case ({rd_issue_fire, rd_fire})
                    2'b10:   credit <= credit + CW'(1);
                    2'b01:   credit <= credit - CW'(1);
                    default: ;
                endcase
            end
            if (push)    wr_ptr <= wr_ptr + CW'(1);
            if (rd_fire) rd_ptr <= rd_ptr + CW'(1);
        end
    end

    // Return FIFO storage; contents are only observed through the pointers
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[IW-1:0]] <= bus.mem_resp_data;
    end
endmodule

// File: tb/tb_io_mem_burst_engine.sv
// Directed bench for io_mem_burst_engine: a bench memory model, expected op/data queues and
// a negedge compare process, plus literal end-of-test expectations.
`timescale 1ns/1ps
module tb_io_mem_burst_engine;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    io_mem_burst_if #(.AWIDTH(AW), .DWIDTH(DW)) bus();

    io_mem_burst_engine #(.AWIDTH(AW), .DWIDTH(DW), .MAX_OUTSTANDING(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } op_t;
    typedef struct packed { int due; logic [31:0] data; } resp_t;

    op_t         exp_ops[$];
    logic [31:0] exp_rd[$];
    resp_t       pend[$];

    int vectors = 0, miscompares = 0, cyc = 0;
    int mem_lat = 1, rr_release = 0;
    bit mr_toggle = 1'b0;
    int rd_fires = 0, wr_fires = 0, dlv = 0, st_fires = 0, out_rd = 0, out_dlv = 0;
    logic [31:0] last_rd_addr = '0, last_wr_addr = '0;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [31:0] wd(input logic [7:0] tag, input int i);
        return 32'hBE00_0000 | (32'(tag) << 8) | 32'(i);
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic void chk1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endfunction

    function automatic void fail_now(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: event with no expectation", nm);
    endfunction

    // Memory and consumer model: fixed-latency in-order returns, ready patterns
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        bus.mem_req_ready = mr_toggle ? cyc[0] : 1'b1;
        bus.rdata_ready   = (cyc >= rr_release);
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = pend[0].data;
            void'(pend.pop_front());
        end else begin
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = '0;
        end
    end

    // Compare process: every handshake checked against the expectation queues
    always @(negedge clk) begin
        if (rst) begin
            out_rd  = 0;
            out_dlv = 0;
        end else begin
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (bus.mem_req_we) begin
                    wr_fires++;
                    last_wr_addr = bus.mem_req_addr;
                end else begin
                    rd_fires++;
                    out_rd++;
                    last_rd_addr = bus.mem_req_addr;
                    pend.push_back('{due: cyc + mem_lat, data: rd_val(bus.mem_req_addr)});
                end
                if (exp_ops.size() == 0) fail_now("mem_op");
                else begin
                    op_t e;
                    e = exp_ops.pop_front();
                    chk1("mem_we", bus.mem_req_we, e.we);
                    chk("mem_addr", bus.mem_req_addr, e.addr);
                    if (e.we) chk("mem_wdata", bus.mem_req_wdata, e.wdata);
                end
            end
            if (bus.rdata_valid && bus.rdata_ready) begin
                dlv++;
                out_dlv++;
                if (exp_rd.size() == 0) fail_now("rdata");
                else chk("rdata", bus.rdata, exp_rd.pop_front());
            end
            if (bus.resp_write_status_valid) begin
                chk1("wstatus", bus.resp_write_status, 1'b1);
                if (bus.resp_write_status_ready) st_fires++;
            end
            chk1("outstanding_le_4", (out_rd - out_dlv) <= 4, 1'b1);
        end
    end

    task automatic push_read(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            exp_ops.push_back('{we: 1'b0, addr: a + 32'(i * 4), wdata: 32'h0});
            exp_rd.push_back(rd_val(a + 32'(i * 4)));
        end
    endtask

    task automatic push_write(input logic [31:0] a, input int n, input logic [7:0] tag);
        for (int i = 0; i < n; i++)
            exp_ops.push_back('{we: 1'b1, addr: a + 32'(i * 4), wdata: wd(tag, i)});
    endtask

    task automatic issue_read(input logic [31:0] a, input int n);
        bit acc = 1'b0;
        push_read(a, n);
        @(posedge clk); #1;
        bus.req_read_addr = a; bus.req_read_len = 32'(n); bus.req_read_addr_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk); #1;
            if (bus.req_read_addr_ready) acc = 1'b1;
        end
        chk1("read_accept_timeout", acc, 1'b1);
        @(posedge clk); #1;
        bus.req_read_addr_valid = 1'b0;
    endtask

    task automatic feed_wdata(input int n, input logic [7:0] tag);
        int k = 0;
        for (int c = 0; c < 200 && k < n; c++) begin
            @(posedge clk); #1;
            bus.req_write_data_valid = 1'b1; bus.req_write_data = wd(tag, k);
            @(negedge clk); #1;
            if (bus.req_write_data_ready) k++;
        end
        chk("wdata_feed_timeout", 32'(k), 32'(n));
        @(posedge clk); #1;
        bus.req_write_data_valid = 1'b0;
    endtask

    task automatic issue_write(input logic [31:0] a, input int n, input logic [7:0] tag);
        bit acc = 1'b0;
        push_write(a, n, tag);
        @(posedge clk); #1;
        bus.req_write_addr = a; bus.req_write_len = 32'(n); bus.req_write_addr_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk); #1;
            if (bus.req_write_addr_ready) acc = 1'b1;
        end
        chk1("write_accept_timeout", acc, 1'b1);
        @(posedge clk); #1;
        bus.req_write_addr_valid = 1'b0;
        feed_wdata(n, tag);
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk); #1;
            if (exp_ops.size() == 0 && exp_rd.size() == 0) done = 1'b1;
        end
        chk1("drain_timeout", done, 1'b1);
        @(negedge clk); #1;
    endtask

    task automatic wait_status(input int s0, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk); #1;
            if (st_fires > s0) done = 1'b1;
        end
        chk1("status_timeout", done, 1'b1);
    endtask

    initial begin
        int s_rd, s_wr, s_dlv, s_st;
        bit seen;
        bus.req_read_addr = '0;  bus.req_read_addr_valid = 1'b0;  bus.req_read_len = '0;
        bus.req_write_addr = '0; bus.req_write_addr_valid = 1'b0; bus.req_write_len = '0;
        bus.req_write_data = '0; bus.req_write_data_valid = 1'b0;
        bus.resp_write_status_ready = 1'b1;

        repeat (2) @(posedge clk);
        #2;
        chk1("rst_rd_addr_ready", bus.req_read_addr_ready, 1'b0);
        chk1("rst_wr_addr_ready", bus.req_write_addr_ready, 1'b0);
        chk1("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
        chk1("rst_rdata_valid", bus.rdata_valid, 1'b0);
        chk("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        chk1("idle_rd_addr_ready", bus.req_read_addr_ready, 1'b1);

        // 1: read 9 beats from 0x100, latency 1
        s_rd = rd_fires; s_dlv = dlv; s_st = st_fires;
        issue_read(32'h100, 9);
        wait_drain(300);
        chk("t1_mem_reads", 32'(rd_fires - s_rd), 32'd9);
        chk("t1_beats", 32'(dlv - s_dlv), 32'd9);
        chk("t1_last_addr", last_rd_addr, 32'h120);
        chk("t1_no_status", 32'(st_fires - s_st), 32'd0);
        chk1("t1_back_idle", bus.req_read_addr_ready, 1'b1);

        // 2: read 16 beats with the consumer stalled for 20 cycles
        s_rd = rd_fires; s_dlv = dlv;
        rr_release = cyc + 20;
        issue_read(32'h200, 16);
        repeat (12) @(negedge clk);
        #1;
        chk("t2_reads_while_stalled", 32'(rd_fires - s_rd), 32'd4);
        chk1("t2_rdata_valid_held", bus.rdata_valid, 1'b1);
        wait_drain(400);
        chk("t2_beats", 32'(dlv - s_dlv), 32'd16);
        chk("t2_last_addr", last_rd_addr, 32'h23C);

        // 3: write 4 beats to 0x400 with toggling memory ready; status held until taken
        s_wr = wr_fires; s_st = st_fires;
        mr_toggle = 1'b1;
        bus.resp_write_status_ready = 1'b0;
        issue_write(32'h400, 4, 8'h03);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk); #1;
            if (bus.resp_write_status_valid) seen = 1'b1;
        end
        chk1("t3_status_seen", seen, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk1("t3_status_holds", bus.resp_write_status_valid, 1'b1);
        end
        @(posedge clk); #1; bus.resp_write_status_ready = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk1("t3_status_dropped", bus.resp_write_status_valid, 1'b0);
        chk("t3_status_count", 32'(st_fires - s_st), 32'd1);
        chk("t3_mem_writes", 32'(wr_fires - s_wr), 32'd4);
        chk("t3_last_addr", last_wr_addr, 32'h40C);
        mr_toggle = 1'b0;

        // 4: read and write requested in the same idle cycle
        s_dlv = dlv; s_st = st_fires;
        push_read(32'h800, 5);
        push_write(32'h900, 2, 8'h04);
        @(posedge clk); #1;
        bus.req_read_addr = 32'h800;  bus.req_read_len = 32'd5;  bus.req_read_addr_valid = 1'b1;
        bus.req_write_addr = 32'h900; bus.req_write_len = 32'd2; bus.req_write_addr_valid = 1'b1;
        @(negedge clk); #1;
        chk1("t4_read_wins", bus.req_read_addr_ready, 1'b1);
        chk1("t4_write_blocked", bus.req_write_addr_ready, 1'b0);
        @(posedge clk); #1; bus.req_read_addr_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk); #1;
            if (bus.req_write_addr_ready) seen = 1'b1;
        end
        chk1("t4_write_accepted", seen, 1'b1);
        chk("t4_read_done_first", 32'(exp_rd.size()), 32'd0);
        chk("t4_read_beats", 32'(dlv - s_dlv), 32'd5);
        @(posedge clk); #1; bus.req_write_addr_valid = 1'b0;
        feed_wdata(2, 8'h04);
        wait_status(s_st, 50);
        wait_drain(50);

        // 5: zero-length bursts
        s_rd = rd_fires; s_wr = wr_fires; s_dlv = dlv; s_st = st_fires;
        issue_write(32'hA00, 0, 8'h05);
        repeat (4) @(negedge clk);
        #1;
        chk("t5_wlen0_status", 32'(st_fires - s_st), 32'd1);
        chk("t5_wlen0_no_ops", 32'(wr_fires - s_wr), 32'd0);
        issue_read(32'hB00, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("t5_rlen0_no_ops", 32'(rd_fires - s_rd), 32'd0);
        chk("t5_rlen0_no_beats", 32'(dlv - s_dlv), 32'd0);
        chk1("t5_rlen0_idle", bus.req_read_addr_ready, 1'b1);

        // 6: reset after 3 of 8 beats, latency 3 so responses arrive after the abort
        mem_lat = 3;
        s_dlv = dlv;
        issue_read(32'h1000, 8);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk); #1;
            if (dlv - s_dlv == 3) seen = 1'b1;
        end
        chk1("t6_three_beats", seen, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        exp_ops.delete();
        exp_rd.delete();
        chk1("t6_rst_mem_req_valid", bus.mem_req_valid, 1'b0);
        chk1("t6_rst_rdata_valid", bus.rdata_valid, 1'b0);
        chk("t6_rst_rdata", bus.rdata, 32'h0);
        chk1("t6_rst_rd_ready", bus.req_read_addr_ready, 1'b0);
        chk1("t6_rst_wr_ready", bus.req_write_addr_ready, 1'b0);
        @(negedge clk); #1;
        rst = 1'b0;
        s_dlv = dlv;
        repeat (8) @(negedge clk);
        #1;
        chk("t6_stale_dropped", 32'(dlv - s_dlv), 32'd0);
        mem_lat = 1;
        issue_read(32'h2000, 2);
        wait_drain(100);
        chk("t6_new_beats", 32'(dlv - s_dlv), 32'd2);
        chk("t6_new_last_addr", last_rd_addr, 32'h2004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end
endmodule
